// File: rtl/mem_arbiter_mu0.sv
// rtl/mem_arbiter_mu0.sv - two-port round-robin arbiter in front of a single-port synchronous memory
module mem_arbiter_mu0 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_readdata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_port_q, cmd_port_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              sel;
    logic              in_access;
    logic              in_rdata;

    // Round-robin pick: a lone requester wins, contention goes to the port not granted last
    always_comb begin
        sel = m1_req;
        if (m0_req && m1_req) begin
            sel = ~last_grant_q;
        end
    end

    // Next-state logic: latch the winning command in IDLE, capture read data in RDATA
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_port_d   = cmd_port_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = ACCESS;
                    last_grant_d = sel;
                    cmd_port_d   = sel;
                    cmd_write_d  = sel ? m1_write     : m0_write;
                    cmd_addr_d   = sel ? m1_address   : m0_address;
                    cmd_wdata_d  = sel ? m1_writedata : m0_writedata;
                end
            end
            ACCESS: begin
                state_d = cmd_write_q ? IDLE : RDATA;
            end
            RDATA: begin
                state_d = IDLE;
                if (cmd_port_q) begin
                    rdata1_d = mem_readdata;
                end else begin
                    rdata0_d = mem_readdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cmd_port_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_port_q   <= cmd_port_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs decoded from state; memory bus is zeroed outside ACCESS, readdata bypasses in RDATA
    always_comb begin
        in_access     = (state_q == ACCESS);
        in_rdata      = (state_q == RDATA);
        busy          = (state_q != IDLE);
        last_grant    = last_grant_q;
        m0_gnt        = in_access && !cmd_port_q;
        m1_gnt        = in_access &&  cmd_port_q;
        m0_rvalid     = in_rdata  && !cmd_port_q;
        m1_rvalid     = in_rdata  &&  cmd_port_q;
        mem_read      = in_access && !cmd_write_q;
        mem_write     = in_access &&  cmd_write_q;
        mem_address   = in_access ? cmd_addr_q  : '0;
        mem_writedata = in_access ? cmd_wdata_q : '0;
        m0_readdata   = m0_rvalid ? mem_readdata : rdata0_q;
        m1_readdata   = m1_rvalid ? mem_readdata : rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter_mu0.sv
// tb/tb_mem_arbiter_mu0.sv - self-checking bench for mem_arbiter_mu0
module tb_mem_arbiter_mu0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
    logic [11:0] m0_address = '0, m1_address = '0;
    logic [15:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic [11:0] mem_address;
    logic        mem_read, mem_write, busy, last_grant;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata = '0;

    logic [15:0] mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_a = '0;
    logic [15:0] pre_d = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_mu0 #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .busy(busy), .last_grant(last_grant)
    );

    // Synchronous memory: read data appears the cycle after mem_read, noise otherwise
    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_write) mem[mem_address] <= mem_writedata;
        mem_readdata <= mem_read ? mem[mem_address] : 16'($urandom);
    end

    task automatic preload(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drop_reqs();
        m0_req = 0; m1_req = 0; m0_write = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        drop_reqs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [67:0] got;
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1; m1_req = 1; m0_address = 12'h3A5; m1_address = 12'h5A3;
        m0_writedata = 16'hFFFF; m1_writedata = 16'hFFFF;
        repeat (2) @(negedge clk);
        got = {busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write, mem_address,
               mem_writedata, m0_readdata, m1_readdata, 1'b0};
        checks++;
        if (got !== 68'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_last_grant got=%b exp=1", last_grant);
        end
        drop_reqs();
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        preload(12'h005, 16'h1234);
        @(negedge clk);
        m0_req = 1; m0_write = 0; m0_address = 12'h005;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, mem_read, mem_write, mem_address, busy, m0_rvalid} !== {4'b1010, 12'h005, 2'b10}) begin
            errors++;
            $display("FAIL read_access got=%b%b%b%b %h busy=%b rv=%b exp=1010 005 busy=1 rv=0",
                     m0_gnt, m1_gnt, mem_read, mem_write, mem_address, busy, m0_rvalid);
        end
        m0_req = 0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_gnt, mem_read, m0_readdata} !== {4'b1000, 16'h1234}) begin
            errors++;
            $display("FAIL read_rvalid got rv0=%b rv1=%b g0=%b rd=%b data=%h exp 1 0 0 0 1234",
                     m0_rvalid, m1_rvalid, m0_gnt, mem_read, m0_readdata);
        end
        @(negedge clk);
        checks++;
        if ({busy, m0_rvalid, m0_readdata, last_grant} !== {2'b00, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL read_hold got busy=%b rv=%b data=%h lg=%b exp 0 0 1234 0",
                     busy, m0_rvalid, m0_readdata, last_grant);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        m1_req = 1; m1_write = 1; m1_address = 12'h0FF; m1_writedata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, mem_read, mem_write, mem_address, mem_writedata, busy}
            !== {4'b0101, 12'h0FF, 16'hBEEF, 1'b1}) begin
            errors++;
            $display("FAIL write_access got g=%b%b r=%b w=%b a=%h d=%h busy=%b exp 01 0 1 0ff beef 1",
                     m0_gnt, m1_gnt, mem_read, mem_write, mem_address, mem_writedata, busy);
        end
        drop_reqs();
        @(negedge clk);
        checks++;
        if ({busy, mem_write, m1_rvalid, last_grant} !== 4'b0001) begin
            errors++;
            $display("FAIL write_done got busy=%b w=%b rv1=%b lg=%b exp 0 0 0 1",
                     busy, mem_write, m1_rvalid, last_grant);
        end
        checks++;
        if (mem[12'h0FF] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_mem got=%h exp=beef", mem[12'h0FF]);
        end
    endtask

    task automatic test_alternate();
        reset_pulse();
        m0_req = 1; m0_address = 12'h010;
        m1_req = 1; m1_address = 12'h020;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            @(negedge clk);
            while (!(m0_gnt || m1_gnt) && n < 6) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if ({m0_gnt, m1_gnt, last_grant} !== ((k % 2) ? 3'b011 : 3'b100)) begin
                errors++;
                $display("FAIL alternate_%0d got g0=%b g1=%b lg=%b exp port %0d", k,
                         m0_gnt, m1_gnt, last_grant, k % 2);
            end
        end
        drop_reqs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_hold();
        @(negedge clk);
        m0_req = 1; m0_write = 0; m0_address = 12'h005;
        @(negedge clk);
        m0_req = 0;
        m1_req = 1; m1_write = 1; m1_address = 12'h040; m1_writedata = 16'h0A0A;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m0_readdata, m1_gnt, m1_rvalid} !== {1'b1, 16'h1234, 2'b00}) begin
            errors++;
            $display("FAIL hold_rdata got rv0=%b d=%h g1=%b rv1=%b exp 1 1234 0 0",
                     m0_rvalid, m0_readdata, m1_gnt, m1_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({busy, m1_gnt, m0_rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL hold_idle got busy=%b g1=%b rv0=%b exp 0 0 0", busy, m1_gnt, m0_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({m1_gnt, mem_write, mem_address, mem_writedata} !== {2'b11, 12'h040, 16'h0A0A}) begin
            errors++;
            $display("FAIL hold_late_grant got g1=%b w=%b a=%h d=%h exp 1 1 040 0a0a",
                     m1_gnt, mem_write, mem_address, mem_writedata);
        end
        drop_reqs();
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [67:0] got;
        bit seen_rv;
        @(negedge clk);
        m0_req = 1; m0_write = 0; m0_address = 12'h005;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        got = {busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write, mem_address,
               mem_writedata, m0_readdata, m1_readdata, 1'b0};
        checks++;
        if (got !== 68'd0 || last_grant !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset_outputs got=%h lg=%b exp=0 lg=1", got, last_grant);
        end
        drop_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        seen_rv = 0;
        repeat (3) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid || m0_gnt || m1_gnt) seen_rv = 1;
        end
        checks++;
        if (seen_rv) begin
            errors++;
            $display("FAIL abort_no_rvalid got activity=1 exp=0");
        end
        m0_req = 1; m0_address = 12'h001;
        m1_req = 1; m1_address = 12'h002;
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, last_grant} !== 3'b100) begin
            errors++;
            $display("FAIL abort_contention got g0=%b g1=%b lg=%b exp 1 0 0", m0_gnt, m1_gnt, last_grant);
        end
        drop_reqs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] ref_mem [0:15];
        bit          pend [2];
        bit          cw [2];
        logic [11:0] ca [2];
        logic [15:0] cd [2];
        logic [15:0] erd [2];
        int          next_idle, acc_c, rv_c;
        bit          acc_p, acc_w, rv_p, lg, sel;
        logic [11:0] acc_a;
        logic [15:0] acc_d, rv_d;
        logic [67:0] got, exp_v;
        bit          in_acc, in_rd;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            preload(12'(i), ref_mem[i]);
        end
        reset_pulse();
        pend[0] = 0; pend[1] = 0; erd[0] = '0; erd[1] = '0;
        next_idle = 0; acc_c = -1; rv_c = -1; lg = 1;
        acc_p = 0; acc_w = 0; acc_a = '0; acc_d = '0; rv_p = 0; rv_d = '0;
        for (int c = 0; c < 600; c++) begin
            in_acc = (c == acc_c);
            in_rd  = (c == rv_c);
            if (in_rd) erd[rv_p] = rv_d;
            exp_v = {c < next_idle, lg, in_acc && !acc_p, in_acc && acc_p, in_rd && !rv_p, in_rd && rv_p,
                     in_acc && !acc_w, in_acc && acc_w, in_acc ? acc_a : 12'h000,
                     in_acc ? acc_d : 16'h0000, erd[0], erd[1]};
            got = {busy, last_grant, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write,
                   mem_address, mem_writedata, m0_readdata, m1_readdata};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d got=%h exp=%h", c, got, exp_v);
            end
            if (in_acc) pend[acc_p] = 0;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    cw[p] = 1'($urandom);
                    ca[p] = 12'($urandom_range(0, 15));
                    cd[p] = 16'($urandom);
                end else if (!pend[p]) begin
                    cw[p] = 1'($urandom);
                    ca[p] = 12'($urandom);
                    cd[p] = 16'($urandom);
                end
            end
            m0_req = pend[0]; m0_write = cw[0]; m0_address = ca[0]; m0_writedata = cd[0];
            m1_req = pend[1]; m1_write = cw[1]; m1_address = ca[1]; m1_writedata = cd[1];
            if (c >= next_idle && (pend[0] || pend[1])) begin
                sel = (pend[0] && pend[1]) ? !lg : pend[1];
                lg = sel;
                acc_c = c + 1; acc_p = sel; acc_w = cw[sel]; acc_a = ca[sel]; acc_d = cd[sel];
                if (acc_w) begin
                    ref_mem[acc_a[3:0]] = acc_d;
                    next_idle = c + 2;
                end else begin
                    rv_c = c + 2; rv_p = sel; rv_d = ref_mem[acc_a[3:0]];
                    next_idle = c + 3;
                end
            end
            @(negedge clk);
        end
        drop_reqs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_alternate();
        test_busy_hold();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
